rmii_tx_frame_arbiter: RTL
==========================

// Module: rmii_tx_frame_arbiter
// PURPOSE
//  Frame-level round-robin arbiter that shares the single 8-bit AXI-Stream TX port of the RMII MAC
//  core among NUM_PORTS requesters (e.g. uDMA channel, test-frame generator).
//  - Locks a grant for a whole frame (through tlast) so frames never interleave.
//  - Enforces a maximum frame length: an over-length frame is truncated and marked bad (tuser=1).
//  - Sits between the requesters and tx_axis_* of the RMII top level, in the clk_int domain.
// PARAMETERS
//  NUM_PORTS   2     number of requesting AXI-Stream sources, 2..8
//  MAX_LEN     1518  max bytes forwarded per frame, 64..16383
// PORTS
//  clk_int          in   1            MAC clock; all logic rising-edge
//  reset_n          in   1            asynchronous active-low reset
//  s_axis_tdata     in   8*NUM_PORTS  source bytes; port i at [8*i+7:8*i]
//  s_axis_tvalid    in   NUM_PORTS    per-source valid
//  s_axis_tlast     in   NUM_PORTS    per-source end of frame
//  s_axis_tuser     in   NUM_PORTS    per-source bad-frame flag
//  s_axis_tready    out  NUM_PORTS    per-source ready
//  m_axis_tdata     out  8            to MAC tx_axis_tdata
//  m_axis_tvalid    out  1            to MAC tx_axis_tvalid
//  m_axis_tlast     out  1            to MAC tx_axis_tlast
//  m_axis_tuser     out  1            to MAC tx_axis_tuser
//  m_axis_tready    in   1            from MAC tx_axis_tready
//  grant            out  NUM_PORTS    one-hot owner of the current frame; 0 when IDLE
//  busy             out  1            1 in PASS or DRAIN
//  frame_trunc      out  1            1-cycle pulse when a frame is truncated
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, busy=0, frame_trunc=0, byte_cnt=0, rr_ptr=NUM_PORTS-1
//   (port 0 wins first). m_axis_tvalid=0 and s_axis_tready=0 while in IDLE.
//  Beat = cycle where m_axis_tvalid & m_axis_tready (PASS), or s_tvalid[sel] & s_tready[sel] (DRAIN).
//  States:
//   IDLE : if any s_axis_tvalid -> sel = first requester after rr_ptr (wrapping modulo NUM_PORTS).
//          Register grant=onehot(sel), rr_ptr=sel, byte_cnt=0, go PASS.
//          No data moves in IDLE; first beat is possible the cycle after the request is seen.
//   PASS : combinational path. m_tdata/tvalid/tuser = source sel.
//          m_tlast = s_tlast[sel] | (byte_cnt==MAX_LEN-1); s_tready[sel]=m_axis_tready; others 0.
//          Per beat byte_cnt++ (width $clog2(MAX_LEN+1), never wraps).
//          Beat with s_tlast -> IDLE, grant=0.
//          Beat with byte_cnt==MAX_LEN-1 and !s_tlast -> force m_tlast=1, m_tuser=1;
//           frame_trunc=1 next cycle; go DRAIN.
//   DRAIN: m_axis_tvalid=0. s_tready[sel]=1; source bytes discarded.
//          Beat with s_tlast -> IDLE, grant=0.
//  Lock: grant held while source sel deasserts tvalid mid-frame (no timeout); m_tvalid follows it.
//  Non-granted sources see tready=0; their tvalid/tdata must be held (AXI rule), and are never dropped.
//  Fairness: after a frame from port k, port k is lowest priority in the next IDLE decision.
//  Single request: same port may win back-to-back; one IDLE cycle separates frames.
//  Frame of exactly MAX_LEN bytes with tlast on byte MAX_LEN: normal end, no truncation, tuser passed.
//  Asynchronous reset mid-frame: immediate return to IDLE, all outputs 0. Downstream sees a frame
//   without tlast; the MAC FIFO is reset by the same reset.
//  m_axis_tready ignored in IDLE and DRAIN.
// TESTING
//  1 Port0 sends 64-byte frame, m_tready=1 -> 64 beats identical on m_*, tlast on byte 64,
//    grant=01 then 00, frame_trunc=0.
//  2 Ports 0,1 both assert tvalid from reset with 3 frames each -> output frame order 0,1,0,1,0,1;
//    no interleaved bytes.
//  3 MAX_LEN=64, port1 sends 100 bytes -> 64 bytes out, byte 64 has tlast=1 tuser=1,
//    frame_trunc pulse once, 36 bytes drained with m_tvalid=0.
//  4 Random m_axis_tready (50%) and source tvalid gaps on 1500-byte frames -> byte-exact output,
//    grant stable for whole frame.
//  5 Assert reset_n=0 at byte 20 of a frame -> same cycle grant=0, m_tvalid=0, busy=0;
//    after release, port 0 wins first.
//  6 Source tuser=1 on tlast of a 60-byte frame -> m_tuser=1 on the last beat, frame_trunc=0.

Source files
------------

// File: rtl/rmii_tx_frame_arbiter.sv
// rmii_tx_frame_arbiter: frame-locked round-robin arbiter for the RMII MAC AXI-Stream TX port
module rmii_tx_frame_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int MAX_LEN   = 1518
) (
  input  logic                   clk_int,
  input  logic                   reset_n,
  input  logic [8*NUM_PORTS-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]   s_axis_tlast,
  input  logic [NUM_PORTS-1:0]   s_axis_tuser,
  output logic [NUM_PORTS-1:0]   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic                   m_axis_tready,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   busy,
  output logic                   frame_trunc
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;
  state_t state;
  logic [PW-1:0] sel, rr_ptr, nxt;
  logic [CW-1:0] byte_cnt;
  logic pass, drain, s_valid, s_last, s_user, at_max, beat;
  int best, d;
  assign pass    = state == PASS;
  assign drain   = state == DRAIN;
  assign s_valid = s_axis_tvalid[sel];
  assign s_last  = s_axis_tlast[sel];
  assign s_user  = s_axis_tuser[sel];
  assign at_max  = byte_cnt == CW'(MAX_LEN - 1);
  assign beat    = pass ? (s_valid & m_axis_tready) : (drain & s_valid);
  assign m_axis_tdata  = pass ? s_axis_tdata[8*sel +: 8] : 8'h00;
  assign m_axis_tvalid = pass & s_valid;
  assign m_axis_tlast  = pass & (s_last | at_max);
  assign m_axis_tuser  = pass & (s_user | (at_max & ~s_last));
  assign s_axis_tready = pass ? (grant & {NUM_PORTS{m_axis_tready}}) : drain ? grant : '0;
  // Next owner: the requester closest after rr_ptr in wrapping order
  always_comb begin
    nxt  = rr_ptr;
    best = NUM_PORTS;
    d    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      d = (i + NUM_PORTS - 1 - int'(rr_ptr)) % NUM_PORTS;
      if (s_axis_tvalid[i] && d < best) begin
        best = d;
        nxt  = PW'(i);
      end
    end
  end
  // Frame FSM: grant in IDLE, forward in PASS, discard the over-length tail in DRAIN
  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      frame_trunc <= 1'b0;
      byte_cnt    <= '0;
      sel         <= '0;
      rr_ptr      <= PW'(NUM_PORTS - 1);
    end else begin
      frame_trunc <= 1'b0;
      case (state)
        IDLE: if (|s_axis_tvalid) begin
          state    <= PASS;
          grant    <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << nxt;
          sel      <= nxt;
          rr_ptr   <= nxt;
          byte_cnt <= '0;
          busy     <= 1'b1;
        end
        PASS: if (beat) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (s_last) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else if (at_max) begin
            state       <= DRAIN;
            frame_trunc <= 1'b1;
          end
        end
        DRAIN: if (beat && s_last) begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
